// File: rtl/fetch_queue.sv
// Instruction fetch unit: drives the ROM address, prefetches {pc, instr} into a small FIFO,
// and hands entries to decode over valid/ready. A redirect flushes the FIFO and restarts fetch.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W = 8,
  parameter int INSTR_W = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [PC_W-1:0]              rom_addr,
  input  logic [INSTR_W-1:0]           rom_instr,
  input  logic                         redirect,
  input  logic [PC_W-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_W-1:0]           out_instr,
  output logic [PC_W-1:0]              out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PC_W-1:0]    fpc;
  logic [AW-1:0]      head;
  logic [AW-1:0]      tail;
  logic [CW-1:0]      occ;
  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               empty;
  logic               pop;
  logic               push;

  assign empty     = (occ == '0);
  assign out_valid = ~empty & ~redirect;
  assign pop       = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full queue can still accept.
  assign push      = ~redirect & ((occ != FULL) | pop);
  assign rom_addr  = fpc;
  assign count     = occ;
  assign out_instr = empty ? '0 : instr_mem[head];
  assign out_pc    = empty ? '0 : pc_mem[head];

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc  <= RESET_PC;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (redirect) begin
      fpc  <= redirect_pc;
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
        fpc  <= fpc + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      if (push && !pop) occ <= occ + 1'b1;
      else if (pop && !push) occ <= occ - 1'b1;
    end
  end

  // Storage needs no reset: entries are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      pc_mem[tail]    <= fpc;
      instr_mem[tail] <= rom_instr;
    end
  end

endmodule
